// File: rtl/vload_gather.sv
// vload_gather: strided vector gather load.
// Issues one memory read per lane (base + idx*stride) over a single-outstanding request port,
// collects up to five 32-bit lanes, then writes them to the vector register file in one cycle.
// Optional build macro VLOAD_TIMEOUT_EN adds an 8-bit WAIT-state watchdog that aborts the
// load with an err pulse when no read data arrives for 255 cycles.

module vload_gather #(
    parameter int unsigned MAXLEN = 5,
    parameter int unsigned AW     = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [31:0]   stride,
    input  logic [2:0]    vsize,
    input  logic [3:0]    vd,
    output logic          ready,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          vector_op,
    output logic [2:0]    vector_size,
    output logic [3:0]    wa3,
    output logic [31:0]   wd1,
    output logic [31:0]   wd2,
    output logic [31:0]   wd3,
    output logic [31:0]   wd4,
    output logic [31:0]   wd5,
    output logic          done,
    output logic          err
);

    localparam int unsigned NUM_LANES = 5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [AW-1:0]                   addr_q, addr_d;
    logic [31:0]                     stride_q, stride_d;
    logic [2:0]                      vsize_q, vsize_d;
    logic [3:0]                      vd_q, vd_d;
    logic [2:0]                      idx_q, idx_d;
    logic [NUM_LANES-1:0][31:0]      lanes_q, lanes_d;
    logic                            err_q, err_d;
    logic                            vsize_ok;
    logic [NUM_LANES-1:0][31:0]      wd_lane;
`ifdef VLOAD_TIMEOUT_EN
    logic [7:0]                      tmo_q, tmo_d;
`endif

    assign vsize_ok = (vsize != 3'd0) && (32'(vsize) <= MAXLEN);

    // Next-state logic: FSM sequencing, request address walk and lane capture
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        vsize_d  = vsize_q;
        vd_d     = vd_q;
        idx_d    = idx_q;
        lanes_d  = lanes_q;
        err_d    = 1'b0;
`ifdef VLOAD_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (vsize_ok) begin
                        addr_d   = base_addr;
                        stride_d = stride;
                        vsize_d  = vsize;
                        vd_d     = vd;
                        idx_d    = 3'd0;
                        lanes_d  = '0;
                        state_d  = REQ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // addr_q is only advanced after read data returns, so it holds while ungranted
                if (mem_gnt) begin
                    state_d = WAIT;
`ifdef VLOAD_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (idx_q < 3'(NUM_LANES)) begin
                        lanes_d[idx_q] = mem_rdata;
                    end
                    if (idx_q == vsize_q - 3'd1) begin
                        state_d = WRITE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        addr_d  = addr_q + AW'(stride_q);
                        state_d = REQ;
                    end
`ifdef VLOAD_TIMEOUT_EN
                    tmo_d = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    // This cycle is the 255th consecutive WAIT cycle without data
                    if (tmo_q == 8'd254) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            vsize_q  <= '0;
            vd_q     <= '0;
            idx_q    <= '0;
            lanes_q  <= '0;
            err_q    <= 1'b0;
`ifdef VLOAD_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            vsize_q  <= vsize_d;
            vd_q     <= vd_d;
            idx_q    <= idx_d;
            lanes_q  <= lanes_d;
            err_q    <= err_d;
`ifdef VLOAD_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Output decode: write-port fields are forced to zero outside the WRITE cycle
    always_comb begin
        ready       = (state_q == IDLE);
        mem_req     = (state_q == REQ);
        mem_addr    = mem_req ? addr_q : '0;
        vector_op   = (state_q == WRITE);
        done        = vector_op;
        wa3         = vector_op ? vd_q : 4'd0;
        vector_size = vector_op ? vsize_q : 3'd0;
        err         = err_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            wd_lane[i] = (vector_op && (3'(i) < vsize_q)) ? lanes_q[i] : 32'd0;
        end
    end

    assign wd1 = wd_lane[0];
    assign wd2 = wd_lane[1];
    assign wd3 = wd_lane[2];
    assign wd4 = wd_lane[3];
    assign wd5 = wd_lane[4];

endmodule

// File: tb/tb_vload_gather.sv
// Scoreboard bench for vload_gather: stimulus pushes expected addresses, writes and errors;
// a negedge monitor pops and compares whenever the DUT presents a handshake, write or err.
// Build with VLOAD_TIMEOUT_EN defined to exercise the watchdog path.

module tb_vload_gather;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [2:0]  vsize;
    logic [3:0]  vd;
    logic        ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        vector_op;
    logic [2:0]  vector_size;
    logic [3:0]  wa3;
    logic [31:0] wd1, wd2, wd3, wd4, wd5;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    vload_gather #(
        .MAXLEN (5),
        .AW     (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .stride      (stride),
        .vsize       (vsize),
        .vd          (vd),
        .ready       (ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .vector_op   (vector_op),
        .vector_size (vector_size),
        .wa3         (wa3),
        .wd1         (wd1),
        .wd2         (wd2),
        .wd3         (wd3),
        .wd4         (wd4),
        .wd5         (wd5),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [4:0][31:0] wd;
        logic [3:0]       wa3;
        logic [2:0]       vs;
        int               cyc;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_addr[$];
    logic [31:0] rdata_q[$];
    int          exp_err = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    int          gnt_delay = 0;
    bit          hold_rv = 1'b0;
    bit          pending = 1'b0;
    int          wcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0][31:0] mk5(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] d,
                                              input logic [31:0] e);
        logic [4:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
        return r;
    endfunction

    // Expected addresses, read data and write-port record for one load
    task automatic push_load(input logic [31:0] base, input logic [31:0] str,
                             input logic [2:0] vs, input logic [3:0] vdst,
                             input logic [4:0][31:0] data, input int ecyc);
        wr_t e;
        e.wd  = '0;
        e.wa3 = vdst;
        e.vs  = vs;
        e.cyc = ecyc;
        for (int i = 0; i < int'(vs); i++) begin
            exp_addr.push_back(base + 32'(i) * str);
            rdata_q.push_back(data[i]);
            e.wd[i] = data[i];
        end
        exp_wr.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] s,
                            input logic [2:0] v, input logic [3:0] d);
        base_addr = b;
        stride    = s;
        vsize     = v;
        vd        = d;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(ready && exp_wr.size() == 0 && exp_addr.size() == 0 && exp_err == 0)
               && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            total++;
            bad++;
            $display("FAIL wait_idle: bound %0d expired, wr=%0d addr=%0d err=%0d pending",
                     bound, exp_wr.size(), exp_addr.size(), exp_err);
        end
    endtask

    task automatic wait_write(input int bound);
        int n = 0;
        while (!vector_op && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            total++;
            bad++;
            $display("FAIL wait_write: vector_op not seen within %0d cycles", bound);
        end
    endtask

    // Memory responder: grant after gnt_delay cycles of request, data in the first WAIT cycle
    initial begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            tick();
            if (mem_gnt) pending = 1'b1;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
            if (pending && !hold_rv) begin
                mem_rvalid = 1'b1;
                mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
                pending    = 1'b0;
            end
            if (mem_req) begin
                if (wcnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                end else begin
                    mem_gnt = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_gnt = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard queues
    initial begin
        bit          prev_wait = 1'b0;
        logic [31:0] prev_addr = '0;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (vector_op) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: vector_op=1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wd1", wd1, e.wd[0]);
                    chk("wd2", wd2, e.wd[1]);
                    chk("wd3", wd3, e.wd[2]);
                    chk("wd4", wd4, e.wd[3]);
                    chk("wd5", wd5, e.wd[4]);
                    chk("wa3", wa3, e.wa3);
                    chk("vector_size", vector_size, e.vs);
                    chk("done_with_write", done, 1);
                    if (e.cyc >= 0) chk("write_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_write_port_zero",
                    |{done, wa3, vector_size, wd1, wd2, wd3, wd4, wd5}, 0);
            end
            if (err) begin
                chk("err_expected", exp_err > 0, 1);
                if (exp_err > 0) exp_err--;
            end
            if (mem_req && mem_gnt) begin
                if (exp_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: addr=0x%0h required no request", mem_addr);
                end else begin
                    chk("mem_addr", mem_addr, exp_addr.pop_front());
                end
            end
            if (mem_req && prev_wait) chk("addr_stable", mem_addr, prev_addr);
            prev_wait = mem_req && !mem_gnt;
            prev_addr = mem_addr;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        stride    = '0;
        vsize     = '0;
        vd        = '0;
        repeat (3) tick();
        chk("rst_ready", ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_vector_op", vector_op, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;
        tick();

        // vsize 5, immediate grant/data: write 11 cycles after start
        push_load(32'h100, 32'd4, 3'd5, 4'd7, mk5(3, 4, 5, 6, 7), cyc + 11);
        do_start(32'h100, 32'd4, 3'd5, 4'd7);
        wait_write(100);
        tick();
        chk("b2b_ready", ready, 1);

        // Back-to-back start in first IDLE cycle; grant delayed 3 cycles
        gnt_delay = 3;
        push_load(32'h2000, 32'h10, 3'd2, 4'd3, mk5(32'hAAAA0001, 32'hBBBB0002, 0, 0, 0), -1);
        do_start(32'h2000, 32'h10, 3'd2, 4'd3);
        wait_idle(200);
        gnt_delay = 0;

        // Illegal sizes: one err each, stay in IDLE, no request
        exp_err++;
        do_start(32'h300, 32'd4, 3'd0, 4'd1);
        chk("err0_ready", ready, 1);
        chk("err0_no_req", mem_req, 0);
        exp_err++;
        do_start(32'h300, 32'd4, 3'd6, 4'd1);
        chk("err6_ready", ready, 1);
        chk("err6_no_req", mem_req, 0);
        wait_idle(20);

        // Address wrap-around; a start while busy must be ignored
        push_load(32'hFFFF_FFFC, 32'd8, 3'd3, 4'd15, mk5(32'h11, 32'h22, 32'h33, 0, 0), cyc + 7);
        do_start(32'hFFFF_FFFC, 32'd8, 3'd3, 4'd15);
        tick();
        do_start(32'h5000, 32'd4, 3'd5, 4'd9);
        wait_idle(100);

        // Reset for two cycles in the middle of a 4-lane load
        exp_addr.push_back(32'h800);
        exp_addr.push_back(32'h804);
        rdata_q.push_back(32'h0101);
        rdata_q.push_back(32'h0202);
        do_start(32'h800, 32'd4, 3'd4, 4'd6);
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_ready", ready, 1);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_vector_op", vector_op, 0);
        chk("midrst_err", err, 0);
        tick();
        reset_n = 1'b1;
        rdata_q.delete();
        pending = 1'b0;
        tick();
        chk("midrst_ready_after", ready, 1);
        chk("midrst_addrs_seen", exp_addr.size(), 0);

        // Recovery: single lane, zero stride
        push_load(32'h40, 32'd0, 3'd1, 4'd2, mk5(32'h1234_5678, 0, 0, 0, 0), cyc + 3);
        do_start(32'h40, 32'd0, 3'd1, 4'd2);
        wait_idle(50);

        // Read data withheld for 300 cycles
        hold_rv = 1'b1;
`ifdef VLOAD_TIMEOUT_EN
        exp_addr.push_back(32'h900);
        rdata_q.push_back(32'h9999);
        exp_err++;
`else
        push_load(32'h900, 32'd4, 3'd1, 4'd5, mk5(32'h9999, 0, 0, 0, 0), -1);
`endif
        do_start(32'h900, 32'd4, 3'd1, 4'd5);
        repeat (300) tick();
`ifdef VLOAD_TIMEOUT_EN
        chk("timeout_ready", ready, 1);
`else
        chk("wait_holds", ready, 0);
`endif
        hold_rv = 1'b0;
        wait_idle(50);

        repeat (5) tick();
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("addr_queue_empty", exp_addr.size(), 0);
        chk("err_queue_empty", exp_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
